// File: rtl/palette_fade_lut.sv
// Colour-index to RGB565 lookup through a writable palette RAM, with a
// transparency flag and a tick-driven global brightness fade on the output stage.

module palette_fade_scale #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_c,
    input  logic [4:0]   i_lvl,
    output logic [W-1:0] o_c
);
    logic [W+4:0] w_prod;

    // The product never exceeds c*16, so truncating after >>4 drops nothing.
    assign w_prod = {5'b0, i_c} * {{W{1'b0}}, i_lvl};
    assign o_c    = W'(w_prod >> 4);
endmodule

module palette_fade_lut #(
    parameter int INDEX_W    = 4,
    parameter int NUM_PAL    = 4,
    parameter int TRANSP_EN  = 1,
    parameter int TRANSP_IDX = 0,
    localparam int PAL_W     = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_pix_valid_in,
    input  logic [INDEX_W-1:0] i_pix_index,
    input  logic [PAL_W-1:0]   i_pal_sel,
    input  logic               i_wr_en,
    input  logic [PAL_W-1:0]   i_wr_pal,
    input  logic [INDEX_W-1:0] i_wr_index,
    input  logic [15:0]        i_wr_data,
    input  logic               i_fade_start,
    input  logic               i_fade_dir,
    input  logic               i_fade_tick,
    output logic               o_fade_busy,
    output logic [4:0]         o_fade_level,
    output logic               o_out_valid,
    output logic [15:0]        o_out_rgb,
    output logic               o_out_transp
);
    localparam int DEPTH = 2 ** INDEX_W;

    typedef enum logic {IDLE, FADING} state_t;

    logic [15:0]  r_ram [NUM_PAL][DEPTH];
    logic [1:0]   r_vld_pipe;
    logic [15:0]  r_s1_rgb;
    logic         r_s1_transp;
    logic [15:0]  r_out_rgb;
    logic         r_out_transp;
    state_t       r_state, w_state_nxt;
    logic [4:0]   r_level, w_level_nxt;
    logic         r_dir, w_dir_nxt;
    logic [4:0]   w_target;
    logic         w_wr_ok, w_rd_ok, w_transp;
    logic [15:0]  w_rd_data, w_scaled;

    assign w_wr_ok   = ({1'b0, i_wr_pal}  < (PAL_W+1)'(NUM_PAL));
    assign w_rd_ok   = ({1'b0, i_pal_sel} < (PAL_W+1)'(NUM_PAL));
    assign w_rd_data = w_rd_ok ? r_ram[i_pal_sel][i_pix_index] : 16'h0000;
    assign w_transp  = (TRANSP_EN != 0) && (i_pix_index == INDEX_W'(TRANSP_IDX));

    // Writes and the stage-1 read share an edge, so a same-entry lookup sees old data.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int p = 0; p < NUM_PAL; p++)
                for (int i = 0; i < DEPTH; i++)
                    r_ram[p][i] <= 16'h0000;
        end else if (i_wr_en && w_wr_ok) begin
            r_ram[i_wr_pal][i_wr_index] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld_pipe   <= '0;
            r_s1_rgb     <= 16'h0000;
            r_s1_transp  <= 1'b0;
            r_out_rgb    <= 16'h0000;
            r_out_transp <= 1'b0;
        end else begin
            r_vld_pipe   <= {r_vld_pipe[0], i_pix_valid_in};
            r_s1_rgb     <= w_rd_data;
            r_s1_transp  <= w_transp;
            r_out_rgb    <= w_scaled;
            r_out_transp <= r_s1_transp;
        end
    end

    // Scaled with the level being loaded on this same edge.
    palette_fade_scale #(.W(5)) u_scale_r (
        .i_c(r_s1_rgb[15:11]), .i_lvl(w_level_nxt), .o_c(w_scaled[15:11]));
    palette_fade_scale #(.W(6)) u_scale_g (
        .i_c(r_s1_rgb[10:5]),  .i_lvl(w_level_nxt), .o_c(w_scaled[10:5]));
    palette_fade_scale #(.W(5)) u_scale_b (
        .i_c(r_s1_rgb[4:0]),   .i_lvl(w_level_nxt), .o_c(w_scaled[4:0]));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_level <= 5'd16;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_dir_nxt   = r_dir;
        w_target    = r_dir ? 5'd16 : 5'd0;
        case (r_state)
            IDLE: begin
                if (i_fade_start && (r_level != (i_fade_dir ? 5'd16 : 5'd0))) begin
                    w_dir_nxt   = i_fade_dir;
                    w_state_nxt = FADING;
                end
            end
            FADING: begin
                if (i_fade_tick) begin
                    w_level_nxt = r_dir ? (r_level + 5'd1) : (r_level - 5'd1);
                    if (w_level_nxt == w_target)
                        w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_fade_busy  = (r_state == FADING);
    assign o_fade_level = r_level;
    assign o_out_valid  = r_vld_pipe[1];
    assign o_out_rgb    = r_out_rgb;
    assign o_out_transp = r_out_transp;
endmodule

// File: tb/tb_palette_fade_lut.sv
// Scoreboard bench for palette_fade_lut: directed lookups push hand-computed
// results; a negedge monitor pops and checks data, transparency and latency.

module tb_palette_fade_lut;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic [3:0]  pix_index = '0;
    logic [1:0]  pal_sel = '0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_pal = '0;
    logic [3:0]  wr_index = '0;
    logic [15:0] wr_data = '0;
    logic        fade_start = 1'b0;
    logic        fade_dir = 1'b0;
    logic        fade_tick = 1'b0;
    logic        fade_busy;
    logic [4:0]  fade_level;
    logic        out_valid;
    logic [15:0] out_rgb;
    logic        out_transp;

    typedef struct {
        logic [15:0] rgb;
        logic        transp;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    palette_fade_lut dut (
        .i_clk(clk), .i_rst(rst),
        .i_pix_valid_in(pix_valid), .i_pix_index(pix_index), .i_pal_sel(pal_sel),
        .i_wr_en(wr_en), .i_wr_pal(wr_pal), .i_wr_index(wr_index), .i_wr_data(wr_data),
        .i_fade_start(fade_start), .i_fade_dir(fade_dir), .i_fade_tick(fade_tick),
        .o_fade_busy(fade_busy), .o_fade_level(fade_level),
        .o_out_valid(out_valid), .o_out_rgb(out_rgb), .o_out_transp(out_transp));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got out_valid=1 expected 0 (rgb 0x%0h)", out_rgb);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_rgb", int'(out_rgb), int'(e.rgb));
                chk("out_transp", int'(out_transp), int'(e.transp));
                chk("latency_cycle", cyc, e.cyc);
            end
        end
    end

    // Advance one edge, then clear one-shot strobes.
    task automatic step();
        @(posedge clk);
        #1;
        pix_valid  = 1'b0;
        wr_en      = 1'b0;
        fade_start = 1'b0;
        fade_tick  = 1'b0;
    endtask

    task automatic lookup(input logic [1:0] p, input logic [3:0] idx,
                          input logic [15:0] rgb, input logic t);
        exp_t e;
        pix_valid = 1'b1;
        pal_sel   = p;
        pix_index = idx;
        e.rgb = rgb; e.transp = t; e.cyc = cyc + 2;
        q.push_back(e);
    endtask

    task automatic write(input logic [1:0] p, input logic [3:0] idx, input logic [15:0] d);
        wr_en = 1'b1; wr_pal = p; wr_index = idx; wr_data = d;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            fade_tick = 1'b1;
            step();
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 10) begin
            step();
            n++;
        end
        step();
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_rgb", int'(out_rgb), 0);
        chk("rst_out_transp", int'(out_transp), 0);
        chk("rst_level", int'(fade_level), 16);
        chk("rst_busy", int'(fade_busy), 0);
        rst = 1'b0;
        step();

        lookup(2'd0, 4'd5, 16'h0000, 1'b0);
        step();
        drain();

        // Same-cycle write and read returns the old entry.
        write(2'd1, 4'd3, 16'hF7BE);
        lookup(2'd1, 4'd3, 16'h0000, 1'b0);
        step();
        lookup(2'd1, 4'd3, 16'hF7BE, 1'b0);
        step();
        write(2'd1, 4'd0, 16'hF7BE);
        step();
        write(2'd1, 4'd1, 16'h1234);
        step();
        drain();

        fade_dir = 1'b0; fade_start = 1'b1;
        step();
        chk("fout_busy_start", int'(fade_busy), 1);
        chk("fout_level_start", int'(fade_level), 16);
        ticks(8);
        chk("fout_level8", int'(fade_level), 8);
        chk("fout_busy8", int'(fade_busy), 1);
        lookup(2'd1, 4'd3, 16'h7BCF, 1'b0);
        step();
        drain();
        ticks(8);
        chk("fout_level0", int'(fade_level), 0);
        chk("fout_busy0", int'(fade_busy), 0);
        lookup(2'd1, 4'd3, 16'h0000, 1'b0);
        step();
        drain();

        fade_dir = 1'b0; fade_start = 1'b1;
        step();
        chk("start_at_target_busy", int'(fade_busy), 0);

        fade_dir = 1'b1; fade_start = 1'b1; fade_tick = 1'b1;
        step();
        chk("fin_tick_ignored", int'(fade_level), 0);
        chk("fin_busy", int'(fade_busy), 1);
        ticks(5);
        chk("fin_level5", int'(fade_level), 5);
        fade_dir = 1'b0; fade_start = 1'b1;
        step();
        ticks(1);
        chk("fin_dir_kept", int'(fade_level), 6);
        chk("fin_busy_mid", int'(fade_busy), 1);
        ticks(10);
        chk("fin_level16", int'(fade_level), 16);
        chk("fin_idle", int'(fade_busy), 0);

        lookup(2'd1, 4'd0, 16'hF7BE, 1'b1);
        step();
        lookup(2'd1, 4'd1, 16'h1234, 1'b0);
        step();
        drain();
        lookup(2'd1, 4'd3, 16'hF7BE, 1'b0); step();
        lookup(2'd1, 4'd1, 16'h1234, 1'b0); step();
        lookup(2'd1, 4'd0, 16'hF7BE, 1'b1); step();
        lookup(2'd0, 4'd5, 16'h0000, 1'b0); step();
        drain();

        fade_dir = 1'b0; fade_start = 1'b1;
        step();
        ticks(8);
        lookup(2'd1, 4'd0, 16'h7BCF, 1'b1); step();
        lookup(2'd1, 4'd1, 16'h090A, 1'b0); step();
        drain();
        ticks(3);
        chk("pre_rst_level5", int'(fade_level), 5);

        lookup(2'd1, 4'd3, 16'h0000, 1'b0); step();
        lookup(2'd1, 4'd1, 16'h0000, 1'b0); step();
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        chk("mid_rst_level", int'(fade_level), 16);
        chk("mid_rst_busy", int'(fade_busy), 0);
        chk("mid_rst_valid", int'(out_valid), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        lookup(2'd1, 4'd3, 16'h0000, 1'b0);
        step();
        lookup(2'd1, 4'd1, 16'h0000, 1'b0);
        step();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
